// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the multi-port CPU memory.
package cpu_mem_pkg;

    typedef enum logic [0:0] {CLEAR, READY} mem_state_t;

    localparam int MAX_RD    = 4;
    localparam int MAX_PAR_W = 64;

    function automatic logic par_calc(input logic [MAX_PAR_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/cpu_mem_rd_port.sv
// One registered read port: write-first bypass, per-port valid and optional parity check.
// Parity storage/check is present only when CPU_MEM_PARITY_EN is defined.
module cpu_mem_rd_port
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] mem_data,
`ifdef CPU_MEM_PARITY_EN
    input  logic              mem_par,
`endif
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_perr
);

    logic bypass;
    logic par_bad;

    assign bypass = wr_en && (wr_addr == rd_addr);

`ifdef CPU_MEM_PARITY_EN
    assign par_bad = par_calc(MAX_PAR_W'(mem_data)) != mem_par;
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_perr  <= 1'b0;
        end else begin
            rd_valid <= en;
            rd_perr  <= 1'b0;
            if (en) begin
                if (bypass) begin
                    rd_data <= wr_data;
                end else begin
                    rd_data <= mem_data;
                    rd_perr <= par_bad;
                end
            end
        end
    end

endmodule

// File: rtl/cpu_mem_mp.sv
// Multi-read-port CPU memory with one write port and a post-reset clear engine.
// Define CPU_MEM_PARITY_EN to store and check an even-parity bit per word.
module cpu_mem_mp
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int NUM_RD     = 2,
    parameter int INIT_CLEAR = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD-1:0]              re,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
    output logic [NUM_RD-1:0]              rd_valid,
    input  logic                           we,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    output logic                           ready,
    output logic [NUM_RD-1:0]              rd_perr
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    mem_state_t        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              wr_en;
    logic              clr_en;

    assign wr_en  = we & ready & ~rst;
    assign clr_en = (state == CLEAR) & ~rst;

    // ready is registered so it stays low on the cycle after any reset, even with INIT_CLEAR=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= (INIT_CLEAR != 0) ? CLEAR : READY;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == '1) begin
                state <= READY;
                ready <= 1'b1;
            end
        end else begin
            ready <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef CPU_MEM_PARITY_EN
    logic mem_par [DEPTH];

    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem_par[clr_cnt] <= 1'b0;
        end else if (wr_en) begin
            mem_par[wr_addr] <= par_calc(MAX_PAR_W'(wr_data));
        end
    end
`endif

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        cpu_mem_rd_port #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W)
        ) u_port (
            .clk      (clk),
            .rst      (rst),
            .en       (re[p] & ready),
            .rd_addr  (rd_addr[p]),
            .mem_data (mem[rd_addr[p]]),
`ifdef CPU_MEM_PARITY_EN
            .mem_par  (mem_par[rd_addr[p]]),
`endif
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_data  (rd_data[p]),
            .rd_valid (rd_valid[p]),
            .rd_perr  (rd_perr[p])
        );
    end

endmodule

// File: tb/tb_cpu_mem_mp.sv
// Scoreboard bench for cpu_mem_mp using a reduced 1K-word array.
module tb_cpu_mem_mp;

    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int NR    = 2;
    localparam int DEPTH = 1 << AW;

    logic                   clk;
    logic                   rst;
    logic [NR-1:0]          re;
    logic [NR-1:0][AW-1:0]  rd_addr;
    logic [NR-1:0][DW-1:0]  rd_data;
    logic [NR-1:0]          rd_valid;
    logic                   we;
    logic [AW-1:0]          wr_addr;
    logic [DW-1:0]          wr_data;
    logic                   ready;
    logic [NR-1:0]          rd_perr;

    int checks = 0;
    int errors = 0;
    logic [DW:0] exp_q [NR][$];

    cpu_mem_mp #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .NUM_RD     (NR),
        .INIT_CLEAR (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .re       (re),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .ready    (ready),
        .rd_perr  (rd_perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    always @(negedge clk) begin : monitor
        logic [DW:0] e;
        for (int p = 0; p < NR; p++) begin
            if (rd_valid[p] === 1'b1) begin
                checks++;
                if (exp_q[p].size() == 0) begin
                    errors++;
                    $display("FAIL port%0d unexpected_valid: got data %0h, required no valid", p, rd_data[p]);
                end else begin
                    e = exp_q[p].pop_front();
                    if ({rd_perr[p], rd_data[p]} !== e) begin
                        errors++;
                        $display("FAIL port%0d read: got perr=%0b data=%0h, required perr=%0b data=%0h",
                                 p, rd_perr[p], rd_data[p], e[DW], e[DW-1:0]);
                    end
                end
            end else if (rd_perr[p] !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL port%0d perr_without_valid: got %0b, required 0", p, rd_perr[p]);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [NR-1:0] r, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic pe0);
        we         = w;
        wr_addr    = wa;
        wr_data    = wd;
        re         = r;
        rd_addr[0] = a0;
        rd_addr[1] = a1;
        if (r[0] && ready) exp_q[0].push_back({pe0, e0});
        if (r[1] && ready) exp_q[1].push_back({1'b0, e1});
        tick;
        we = 1'b0;
        re = '0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < DEPTH + 16) begin
            tick;
            n++;
        end
    endtask

    initial begin
        int n;
        logic [AW-1:0] a2;
        rst     = 1'b1;
        we      = 1'b0;
        re      = '0;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;

        tick;
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_rd_perr", 32'(rd_perr), 32'd0);
        rst = 1'b0;

        // Clear duration and readback of cleared words
        wait_ready(n);
        check("clear_cycles", 32'(n), 32'(DEPTH));
        drive(1'b0, '0, '0, 2'b11, 10'h000, 10'h000, 16'h0000, 16'h0000, 1'b0);
        drive(1'b0, '0, '0, 2'b11, 10'h1FF, 10'h1FF, 16'h0000, 16'h0000, 1'b0);
        drive(1'b0, '0, '0, 2'b11, 10'h3FF, 10'h3FF, 16'h0000, 16'h0000, 1'b0);
        tick;

        // Fill mem[a]=a, then back-to-back dual-port readback
        for (int a = 0; a < DEPTH; a++)
            drive(1'b1, AW'(a), DW'(a), 2'b00, '0, '0, '0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            a2 = AW'((2 * i) % (DEPTH - 1));
            drive(1'b0, '0, '0, 2'b11, AW'(i), a2, DW'(i), DW'(a2), 1'b0);
        end
        tick;

        // Write-first bypass on both ports
        drive(1'b1, 10'h234, 16'hAAAA, 2'b00, '0, '0, '0, '0, 1'b0);
        drive(1'b1, 10'h234, 16'h5555, 2'b11, 10'h234, 10'h234, 16'h5555, 16'h5555, 1'b0);
        drive(1'b0, '0, '0, 2'b11, 10'h234, 10'h234, 16'h5555, 16'h5555, 1'b0);
        tick;

`ifdef CPU_MEM_PARITY_EN
        drive(1'b1, 10'h040, 16'h0F0F, 2'b00, '0, '0, '0, '0, 1'b0);
        dut.mem[10'h040] = dut.mem[10'h040] ^ 16'h0001;
        drive(1'b0, '0, '0, 2'b01, 10'h040, '0, 16'h0F0E, '0, 1'b1);
        drive(1'b0, '0, '0, 2'b01, 10'h041, '0, 16'h0041, '0, 1'b0);
        tick;
`endif

        // Reset while a read result is being presented
        drive(1'b0, '0, '0, 2'b01, 10'h005, '0, 16'h0005, '0, 1'b0);
        check("pre_rst_valid", 32'(rd_valid[0]), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst_mid_ready", 32'(ready), 32'd0);
        check("rst_mid_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_mid_rd_data", 32'(rd_data), 32'd0);

        // Accesses during clear are dropped
        drive(1'b1, 10'h010, 16'hBEEF, 2'b01, 10'h010, '0, '0, '0, 1'b0);
        check("drop_rd_valid", 32'(rd_valid), 32'd0);
        wait_ready(n);
        check("reclear_cycles", 32'(n), 32'(DEPTH - 1));
        drive(1'b0, '0, '0, 2'b11, 10'h010, 10'h005, 16'h0000, 16'h0000, 1'b0);
        drive(1'b0, '0, '0, 2'b11, 10'h234, 10'h3FF, 16'h0000, 16'h0000, 1'b0);
        tick;
        tick;

        check("port0_queue_empty", 32'(exp_q[0].size()), 32'd0);
        check("port1_queue_empty", 32'(exp_q[1].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
